// File: rtl/fsqrt_iter.sv
// fsqrt_iter: multi-cycle binary32 square root, radix-2 restoring recurrence, round-to-nearest-even.
// Define FSQRT_FLAGS_EN to add the flags output {invalid, inexact}.
module fsqrt_iter #(
  parameter logic [31:0] QNAN = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sqrt_num
`ifdef FSQRT_FLAGS_EN
  ,
  output logic [1:0]  flags
`endif
);

  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [49:0] rad;
  logic [25:0] rem;
  logic [24:0] root;
  logic [7:0]  res_exp;

  logic        sign_in;
  logic [7:0]  exp_in;
  logic [22:0] frac_in;
  logic        accept, is_zero, is_inf, is_special;
  logic [31:0] special_res;
  logic [24:0] m_adj;
  logic [7:0]  exp_half;
  logic [27:0] rem_shift, trial;
  logic        take;
  logic        guard, sticky, round_up;
  logic [23:0] frac_rnd;

  assign {sign_in, exp_in, frac_in} = num1;
  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign is_zero    = (exp_in == 8'h00);
  assign is_inf     = (exp_in == 8'hFF) && (frac_in == 23'd0);
  assign is_special = is_zero || (exp_in == 8'hFF) || sign_in;

  always_comb begin
    special_res = QNAN;
    if (is_zero)
      special_res = {sign_in, 31'd0};
    else if (is_inf && !sign_in)
      special_res = 32'h7F800000;
  end

  // floor((e-127)/2)+127 == floor((e+127)/2); an odd unbiased exponent (even e) doubles the mantissa
  assign exp_half = {1'b0, exp_in[7:1]} + (exp_in[0] ? 8'd64 : 8'd63);
  assign m_adj    = exp_in[0] ? {2'b01, frac_in} : {1'b1, frac_in, 1'b0};

  assign rem_shift = {rem, rad[49:48]};
  assign trial     = {1'b0, root, 2'b01};
  assign take      = (rem_shift >= trial);

  assign guard    = root[0];
  assign sticky   = (rem != 26'd0);
  assign round_up = guard && (sticky || root[1]);
  // A carry out of the fraction leaves the low 23 bits at zero, which is exactly the bumped-exponent encoding
  assign frac_rnd = {1'b0, root[23:1]} + {23'd0, round_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = is_special ? DONE : ITER;
      ITER:    if (cnt == 5'd0) state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      rad      <= '0;
      rem      <= '0;
      root     <= '0;
      res_exp  <= '0;
      sqrt_num <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt     <= 5'd24;
          rad     <= {m_adj, 25'd0};
          rem     <= '0;
          root    <= '0;
          res_exp <= exp_half;
          if (is_special) sqrt_num <= special_res;
        end
        ITER: begin
          rad  <= {rad[47:0], 2'b00};
          rem  <= take ? 26'(rem_shift - trial) : rem_shift[25:0];
          root <= {root[23:0], take};
          cnt  <= cnt - 5'd1;
        end
        ROUND: sqrt_num <= {1'b0, res_exp + {7'd0, frac_rnd[23]}, frac_rnd[22:0]};
        default: ;
      endcase
    end
  end

`ifdef FSQRT_FLAGS_EN
  logic is_nan, invalid_in;
  assign is_nan     = (exp_in == 8'hFF) && (frac_in != 23'd0);
  assign invalid_in = !is_zero && (is_nan || sign_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags <= 2'b00;
    else if (state == IDLE && accept && is_special)
      flags <= {invalid_in, 1'b0};
    else if (state == ROUND)
      flags <= {1'b0, guard | sticky};
  end
`endif

endmodule
